dsp_stream_sequencer: RTL

- Controls sample flow between the playback FIFO (32-bit words) and the audio codec output (24-bit samples).
- Accepts FIFO words under a valid/ready handshake, extracts the 24-bit sample, and enforces strict left/right channel alternation.
- Holds one sample in a registered output stage for the codec, with mute and enable controls and underrun/resync status.
- Sits between the FIFO read port and the DSP/audio-out datapath; it is the block that sequences the DSP stream.

---
 rtl/dsp_stream_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dsp_stream_sequencer.sv
// rtl/dsp_stream_sequencer.sv - FIFO-to-codec sample sequencer with L/R alternation, mute and status counters
module dsp_stream_sequencer #(
    parameter int DATA_W = 24,
    parameter int IN_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              mute,
    input  logic              valid_in_fifo,
    output logic              ready_out_fifo,
    input  logic [IN_W-1:0]   stream_in,
    output logic              valid_out_audio,
    input  logic              ready_in_audio,
    output logic [DATA_W-1:0] stream_out,
    output logic              channel_out,
    output logic [CNT_W-1:0]  underrun_count,
    output logic [CNT_W-1:0]  resync_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXPECT_L = 2'd1,
        S_EXPECT_R = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic                r_channel;
    logic [CNT_W-1:0]    r_underrun_count;
    logic [CNT_W-1:0]    r_resync_count;

    logic                w_out_free;
    logic                w_ready;
    logic                w_accept;
    logic                w_tag;
    logic                w_expected;
    logic                w_match;
    logic                w_load;
    logic                w_xfer;
    logic                w_underrun;
    logic                w_unused_bits;

    assign w_tag         = stream_in[IN_W-1];
    assign w_unused_bits = ^stream_in[IN_W-2:DATA_W];
    assign w_expected    = (r_state == S_EXPECT_R);
    assign w_match       = (w_tag == w_expected);
    assign w_out_free    = !r_valid || ready_in_audio;
    assign w_ready       = enable && (r_state != S_IDLE) && w_out_free;
    assign w_accept      = valid_in_fifo && w_ready;
    assign w_load        = w_accept && w_match;
    assign w_xfer        = r_valid && ready_in_audio;
    assign w_underrun    = enable && (r_state != S_IDLE) && ready_in_audio && !r_valid;

    // Expected channel lives in the state; a mismatched word never advances it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_EXPECT_L;
                end
            end
            S_EXPECT_L, S_EXPECT_R: begin
                if (!enable) begin
                    if (!r_valid) begin
                        w_state_next = S_IDLE;
                    end
                end else if (w_load) begin
                    w_state_next = (r_state == S_EXPECT_L) ? S_EXPECT_R : S_EXPECT_L;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Mute is applied as the word is captured, so a held sample never changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_channel <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_data    <= mute ? '0 : stream_in[DATA_W-1:0];
            r_channel <= w_tag;
        end else if (w_xfer) begin
            r_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun_count <= '0;
            r_resync_count   <= '0;
        end else begin
            if (w_underrun && (r_underrun_count != '1)) begin
                r_underrun_count <= r_underrun_count + CNT_W'(1);
            end
            if (w_accept && !w_match && (r_resync_count != '1)) begin
                r_resync_count <= r_resync_count + CNT_W'(1);
            end
        end
    end

    assign ready_out_fifo  = w_ready;
    assign valid_out_audio = r_valid;
    assign stream_out      = r_data;
    assign channel_out     = r_channel;
    assign underrun_count  = r_underrun_count;
    assign resync_count    = r_resync_count;

endmodule
